// File: rtl/irq_scheduler_pkg.sv
// rtl/irq_scheduler_pkg.sv - shared constants and types for the interrupt scheduler
package irq_scheduler_pkg;

    localparam int NUM_SRC_C = 4;
    localparam int DATA_W_C  = 8;
    localparam int ID_W_C    = 2;

    typedef enum logic [0:0] {IDLE, SERVE} state_e;

    typedef logic [ID_W_C-1:0] src_id_t;

endpackage

// File: rtl/irq_rr_pick.sv
// rtl/irq_rr_pick.sv - combinational descending wrap-around pick starting at ptr
module irq_rr_pick
    import irq_scheduler_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_C
) (
    input  logic [NUM_SRC-1:0] eligible_i,
    input  src_id_t            ptr_i,
    output logic               found_o,
    output src_id_t            winner_o
);

    src_id_t idx;

    // Visit farthest-from-ptr first so the last hit (closest to ptr) wins.
    always_comb begin
        found_o  = |eligible_i;
        winner_o = ptr_i;
        idx      = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = ptr_i - src_id_t'(i);
            if (eligible_i[idx]) begin
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/irq_scheduler.sv
// rtl/irq_scheduler.sv - edge-captured interrupt scheduler with valid/ready grant delivery
module irq_scheduler
    import irq_scheduler_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_C,
    parameter int DATA_W  = DATA_W_C,
    parameter bit RR_EN   = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_SRC-1:0]        interrupt_i,
    input  logic [NUM_SRC-1:0]        mask_i,
    input  logic [NUM_SRC*DATA_W-1:0] data_i,
    input  logic                      ready_i,
    input  logic                      clr_overrun_i,
    output logic                      valid_o,
    output logic [DATA_W-1:0]         data_o,
    output src_id_t                   id_o,
    output logic [NUM_SRC-1:0]        pending_o,
    output logic [NUM_SRC-1:0]        overrun_o
);

    state_e               state_q, state_d;
    logic [NUM_SRC-1:0]   prev_q, prev_d;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [NUM_SRC-1:0]   overrun_q, overrun_d;
    logic                 valid_q, valid_d;
    logic [DATA_W-1:0]    data_q, data_d;
    src_id_t              id_q, id_d;
    src_id_t              ptr_q, ptr_d;

    logic [NUM_SRC-1:0]   irq_edge;
    logic [NUM_SRC-1:0]   clr_vec;
    logic [NUM_SRC-1:0]   eligible;
    logic                 hs;
    logic                 found;
    src_id_t              winner;
    logic [DATA_W-1:0]    win_data;

    assign eligible = pending_q & ~mask_i;

    irq_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .found_o    (found),
        .winner_o   (winner)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (winner == src_id_t'(i)) begin
                win_data = data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        irq_edge = interrupt_i & ~prev_q;
        hs       = (state_q == SERVE) && ready_i;
        clr_vec  = '0;
        if (hs) begin
            clr_vec[id_q] = 1'b1;
        end

        prev_d    = interrupt_i;
        // A fresh edge outranks a same-cycle service clear, and is then not an overrun.
        pending_d = irq_edge | (pending_q & ~clr_vec);
        overrun_d = (clr_overrun_i ? '0 : overrun_q) | (irq_edge & pending_q & ~clr_vec);

        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        id_d    = id_q;
        ptr_d   = ptr_q;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (found) begin
                    id_d    = winner;
                    data_d  = win_data;
                    valid_d = 1'b1;
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                    if (RR_EN) begin
                        ptr_d = id_q - src_id_t'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            id_q      <= '0;
            ptr_q     <= src_id_t'(NUM_SRC - 1);
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign id_o      = id_q;
    assign pending_o = pending_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_irq_scheduler.sv
// tb/tb_irq_scheduler.sv - directed self-checking bench for irq_scheduler
module tb_irq_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  irq;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        ready;
    logic        clr_ovr;

    logic        rr_valid, fp_valid;
    logic [7:0]  rr_data,  fp_data;
    logic [1:0]  rr_id,    fp_id;
    logic [3:0]  rr_pend,  fp_pend;
    logic [3:0]  rr_ovr,   fp_ovr;

    int n_checks;
    int n_fail;

    irq_scheduler #(.NUM_SRC(4), .DATA_W(8), .RR_EN(1'b1)) dut_rr (
        .clk_i(clk), .rst_i(rst), .interrupt_i(irq), .mask_i(mask), .data_i(data),
        .ready_i(ready), .clr_overrun_i(clr_ovr), .valid_o(rr_valid), .data_o(rr_data),
        .id_o(rr_id), .pending_o(rr_pend), .overrun_o(rr_ovr)
    );

    irq_scheduler #(.NUM_SRC(4), .DATA_W(8), .RR_EN(1'b0)) dut_fp (
        .clk_i(clk), .rst_i(rst), .interrupt_i(irq), .mask_i(mask), .data_i(data),
        .ready_i(ready), .clr_overrun_i(clr_ovr), .valid_o(fp_valid), .data_o(fp_data),
        .id_o(fp_id), .pending_o(fp_pend), .overrun_o(fp_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; irq = '0; mask = '0; data = '0; ready = 1'b0; clr_ovr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (rr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rr_valid: got %b want 0", rr_valid); end
        n_checks++; if (rr_id !== 2'd0 || rr_data !== 8'h00) begin n_fail++; $display("FAIL reset_rr_iddata: got id %0d data %h want 0/00", rr_id, rr_data); end
        n_checks++; if (rr_pend !== 4'b0 || rr_ovr !== 4'b0) begin n_fail++; $display("FAIL reset_rr_flags: got pend %b ovr %b want 0000/0000", rr_pend, rr_ovr); end
        n_checks++; if (fp_valid !== 1'b0 || fp_pend !== 4'b0 || fp_ovr !== 4'b0) begin n_fail++; $display("FAIL reset_fp: got v %b pend %b ovr %b want 0", fp_valid, fp_pend, fp_ovr); end
    endtask

    task automatic test_single();
        do_reset();
        irq = 4'b0100; data[16 +: 8] = 8'hC3; ready = 1'b1;
        tick();
        irq = 4'b0000;
        n_checks++; if (rr_pend !== 4'b0100 || rr_valid !== 1'b0) begin n_fail++; $display("FAIL single_pend: got pend %b v %b want 0100/0", rr_pend, rr_valid); end
        tick();
        n_checks++; if (rr_valid !== 1'b1 || rr_id !== 2'd2 || rr_data !== 8'hC3) begin n_fail++; $display("FAIL single_grant: got v %b id %0d data %h want 1/2/c3", rr_valid, rr_id, rr_data); end
        n_checks++; if (fp_valid !== 1'b1 || fp_id !== 2'd2 || fp_data !== 8'hC3) begin n_fail++; $display("FAIL single_grant_fp: got v %b id %0d data %h want 1/2/c3", fp_valid, fp_id, fp_data); end
        tick();
        n_checks++; if (rr_valid !== 1'b0 || rr_pend !== 4'b0000) begin n_fail++; $display("FAIL single_done: got v %b pend %b want 0/0000", rr_valid, rr_pend); end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        irq = 4'b1111; ready = 1'b1;
        tick();
        irq = 4'b0000;
        n_checks++; if (fp_pend !== 4'b1111) begin n_fail++; $display("FAIL fixed_pend: got %b want 1111", fp_pend); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (fp_valid !== 1'b1 || fp_id !== 2'(3 - k)) begin n_fail++; $display("FAIL fixed_grant%0d: got v %b id %0d want 1/%0d", k, fp_valid, fp_id, 3 - k); end
            tick();
            n_checks++; if (fp_valid !== 1'b0) begin n_fail++; $display("FAIL fixed_idle%0d: got v %b want 0", k, fp_valid); end
        end
        n_checks++; if (fp_pend !== 4'b0000) begin n_fail++; $display("FAIL fixed_drain: got %b want 0000", fp_pend); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id [8];
        exp_id = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
        do_reset();
        irq = 4'b1111; ready = 1'b1;
        tick();
        irq = 4'b0000;
        for (int n = 0; n < 8; n++) begin
            tick();
            n_checks++; if (rr_valid !== 1'b1 || rr_id !== exp_id[n]) begin n_fail++; $display("FAIL rr_grant%0d: got v %b id %0d want 1/%0d", n, rr_valid, rr_id, exp_id[n]); end
            irq = 4'b0001 << exp_id[n];
            tick();
            irq = 4'b0000;
            n_checks++; if (rr_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle%0d: got v %b want 0", n, rr_valid); end
        end
        n_checks++; if (rr_pend !== 4'b1111 || rr_ovr !== 4'b0000) begin n_fail++; $display("FAIL rr_final: got pend %b ovr %b want 1111/0000", rr_pend, rr_ovr); end
    endtask

    task automatic test_mask_backpressure();
        do_reset();
        mask = 4'b1000; irq = 4'b1010; data[8 +: 8] = 8'h11; data[24 +: 8] = 8'h33;
        tick();
        irq = 4'b0000;
        tick();
        n_checks++; if (rr_valid !== 1'b1 || rr_id !== 2'd1 || rr_data !== 8'h11) begin n_fail++; $display("FAIL mask_grant: got v %b id %0d data %h want 1/1/11", rr_valid, rr_id, rr_data); end
        for (int c = 0; c < 5; c++) begin
            data[8 +: 8] = 8'hA0 + 8'(c);
            mask = (c == 2) ? 4'b1010 : 4'b1000;
            tick();
            n_checks++; if (rr_valid !== 1'b1 || rr_id !== 2'd1 || rr_data !== 8'h11) begin n_fail++; $display("FAIL hold%0d: got v %b id %0d data %h want 1/1/11", c, rr_valid, rr_id, rr_data); end
        end
        n_checks++; if (rr_pend !== 4'b1010) begin n_fail++; $display("FAIL hold_pend: got %b want 1010", rr_pend); end
        mask = 4'b0000; ready = 1'b1;
        tick();
        n_checks++; if (rr_valid !== 1'b0 || rr_pend !== 4'b1000) begin n_fail++; $display("FAIL unmask_hs: got v %b pend %b want 0/1000", rr_valid, rr_pend); end
        tick();
        n_checks++; if (rr_valid !== 1'b1 || rr_id !== 2'd3 || rr_data !== 8'h33) begin n_fail++; $display("FAIL unmask_grant: got v %b id %0d data %h want 1/3/33", rr_valid, rr_id, rr_data); end
        tick();
        n_checks++; if (rr_pend !== 4'b0000) begin n_fail++; $display("FAIL unmask_drain: got %b want 0000", rr_pend); end
    endtask

    task automatic test_overrun_collision();
        do_reset();
        irq = 4'b0001;
        tick();
        irq = 4'b0000;
        n_checks++; if (rr_ovr !== 4'b0000) begin n_fail++; $display("FAIL ovr_first: got %b want 0000", rr_ovr); end
        tick();
        irq = 4'b0001;
        tick();
        irq = 4'b0000;
        n_checks++; if (rr_ovr !== 4'b0001 || rr_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got ovr %b v %b want 0001/1", rr_ovr, rr_valid); end
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        n_checks++; if (rr_ovr !== 4'b0000) begin n_fail++; $display("FAIL ovr_clr: got %b want 0000", rr_ovr); end
        irq = 4'b0001; ready = 1'b1;
        tick();
        irq = 4'b0000; ready = 1'b0;
        n_checks++; if (rr_pend[0] !== 1'b1 || rr_ovr[0] !== 1'b0 || rr_valid !== 1'b0) begin n_fail++; $display("FAIL collide: got pend %b ovr %b v %b want x1/x0/0", rr_pend, rr_ovr, rr_valid); end
        tick();
        n_checks++; if (rr_valid !== 1'b1 || rr_id !== 2'd0) begin n_fail++; $display("FAIL collide_regrant: got v %b id %0d want 1/0", rr_valid, rr_id); end
        irq = 4'b0001; clr_ovr = 1'b1;
        tick();
        irq = 4'b0000; clr_ovr = 1'b0;
        n_checks++; if (rr_ovr !== 4'b0001) begin n_fail++; $display("FAIL ovr_clr_vs_set: got %b want 0001", rr_ovr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        irq = 4'b0010; ready = 1'b1;
        tick();
        irq = 4'b0000;
        tick();
        tick();
        irq = 4'b1001; ready = 1'b0;
        tick();
        irq = 4'b0000;
        tick();
        n_checks++; if (rr_valid !== 1'b1 || rr_id !== 2'd0) begin n_fail++; $display("FAIL mid_pre_grant: got v %b id %0d want 1/0", rr_valid, rr_id); end
        irq = 4'b0001;
        tick();
        n_checks++; if (rr_ovr !== 4'b0001) begin n_fail++; $display("FAIL mid_pre_ovr: got %b want 0001", rr_ovr); end
        rst = 1'b1; irq = 4'b1001; ready = 1'b1;
        tick();
        rst = 1'b0; ready = 1'b0;
        n_checks++; if (rr_valid !== 1'b0 || rr_pend !== 4'b0000 || rr_ovr !== 4'b0000) begin n_fail++; $display("FAIL mid_reset: got v %b pend %b ovr %b want 0/0000/0000", rr_valid, rr_pend, rr_ovr); end
        n_checks++; if (rr_id !== 2'd0 || rr_data !== 8'h00) begin n_fail++; $display("FAIL mid_reset_iddata: got id %0d data %h want 0/00", rr_id, rr_data); end
        tick();
        n_checks++; if (rr_pend !== 4'b1001 || rr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_held_edge: got pend %b v %b want 1001/0", rr_pend, rr_valid); end
        tick();
        n_checks++; if (rr_valid !== 1'b1 || rr_id !== 2'd3) begin n_fail++; $display("FAIL mid_restart: got v %b id %0d want 1/3", rr_valid, rr_id); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_fixed_priority();
        test_round_robin();
        test_mask_backpressure();
        test_overrun_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_scheduler.md
Name: irq_scheduler

Overview:
- Sequential interrupt scheduler for four 8-bit interrupt sources.
- Captures rising edges on the interrupt lines into sticky pending bits and arbitrates among unmasked pending sources, by fixed priority or round-robin.
- Delivers the winning source's data and id to a downstream consumer over a valid/ready handshake.
- Replaces the ad-hoc combinational interrupt routing with a guaranteed one-at-a-time, no-loss service order.

Parameters:
- NUM_SRC, 4, number of interrupt sources; the design is verified only at 4.
- DATA_W, 8, width of each source data word.
- RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority with bit 3 highest.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- interrupt_i  input  NUM_SRC  interrupt request lines; synchronous to clk_i; rising edge = request.
- mask_i  input  NUM_SRC  1 = source excluded from arbitration; its pending bit is retained.
- data_i  input  NUM_SRC*DATA_W  source data; slot i = data_i[i*DATA_W +: DATA_W].
- ready_i  input  1  consumer accepts the current grant.
- clr_overrun_i  input  1  clears all overrun_o bits.
- valid_o  output  1  grant presented.
- data_o  output  DATA_W  latched data of the granted source.
- id_o  output  2  index of the granted source.
- pending_o  output  NUM_SRC  current pending bits.
- overrun_o  output  NUM_SRC  sticky flag: a new edge arrived while that source was already pending.

Behaviour:
- Reset (rst_i=1 at a clock edge) clears the following. It takes priority over every other event, including mid-grant; no handshake completes in that cycle.
  - Outputs: valid_o=0, data_o=0, id_o=0, pending_o=0, overrun_o=0.
  - Internal: prev_irq=0, ptr=3, state=IDLE.
- Edge detection, every cycle:
  - edge = interrupt_i & ~prev_irq; prev_irq <= interrupt_i.
  - A line already high when reset releases counts as an edge on the first post-reset cycle.
- Pending update, per bit:
  - Set on edge.
  - Cleared on a handshake for that id.
  - If the edge and the handshake clear hit the same bit in the same cycle, the set wins and the bit stays 1; overrun is not flagged.
- Overrun: overrun_o[i] <= 1 when edge[i] && pending[i] && not cleared this cycle.
  - clr_overrun_i clears all bits.
  - If clr_overrun_i and a new overrun coincide, the set wins.
- Arbitration (combinational): eligible = pending & ~mask_i.
  - Search starts at index ptr and descends with wrap-around: ptr, ptr-1, ..., 0, NUM_SRC-1, ...
  - The first eligible index wins.
  - With RR_EN=0, ptr is held at 3, giving fixed priority 3>2>1>0.
- FSM states: IDLE, SERVE.
  - IDLE: if eligible != 0, then at the edge latch id_o=winner and data_o=data_i[winner], set valid_o=1, go to SERVE. Otherwise stay; valid_o=0.
  - SERVE: valid_o=1; id_o and data_o are held stable regardless of data_i, mask_i or new edges.
  - SERVE, handshake (ready_i=1 at an edge): clear pending[id_o] (subject to the edge-wins rule), valid_o <= 0, go to IDLE. If RR_EN=1, ptr <= (id_o-1) mod NUM_SRC.
  - SERVE with ready_i=0: hold indefinitely.
  - Masking the granted source during SERVE does not abort the grant.
  - ready_i in IDLE is ignored.
- Latency:
  - Rising edge of interrupt_i sampled at edge k: pending visible after edge k; valid_o=1 after edge k+1.
  - Back-to-back grants need at least 2 cycles per grant, because each passes through IDLE for one cycle.
- Data timing: data_o is sampled from data_i in the IDLE→SERVE cycle, not at the interrupt edge.
- Masked pending sources remain pending indefinitely and are served once unmasked.

Decomposition:
- Package irq_scheduler_pkg holds:
  - constants NUM_SRC_C=4, DATA_W_C=8, ID_W_C=2;
  - typedef enum logic [0:0] {IDLE, SERVE} state_e;
  - typedef logic [ID_W_C-1:0] src_id_t.
- Sub-module irq_rr_pick: purely combinational. Inputs eligible and ptr; outputs found and winner id. The top holds all state.

Test Plan:
- Reset then single request: pulse interrupt_i=4'b0100, data_i slot2=8'hC3, ready_i=1 → valid_o=1 two cycles after the edge with id_o=2, data_o=8'hC3; one-cycle handshake; pending_o returns to 0.
- Fixed priority, RR_EN=0: edges on all four lines in the same cycle with ready_i=1 → grant order id 3,2,1,0, each valid for one cycle with one IDLE cycle between.
- Round-robin, RR_EN=1: hold all four pending by re-pulsing each line after its service → grant sequence 3,2,1,0,3,2,... with no source served twice before the others.
- Masking and backpressure: mask_i=4'b1000 with sources 3 and 1 pending → id 1 granted first. Holding ready_i=0 for 5 cycles → data_o and id_o stable while data_i changes. Unmask → id 3 served next.
- Overrun and collision: second edge on source 0 while it is pending → overrun_o=4'b0001; clr_overrun_i → 0. An edge on source 0 in the same cycle as its handshake → pending_o[0] stays 1 and overrun_o[0] stays 0.
- Reset mid-operation: assert rst_i while in SERVE with valid_o=1 → next cycle valid_o=0, pending_o=0, overrun_o=0. The post-reset grant order restarts from ptr=3.
